// File: rtl/m_ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Contents:
//   state_t  fetch FSM states (IDLE, BUS, DRAIN)
//   NOP      instruction word substituted for a faulted fetch
//   entry_t  FIFO entry {instr, pc, fault}
package m_ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DRAIN
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } entry_t;

endpackage

// File: rtl/m_ifetch_fifo.sv
// DEPTH-entry synchronous FIFO buffering fetched instruction words.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push, din   write an entry (ignored while flush is high)
//   pop         retire the head entry (ignored while flush is high)
//   flush       empty the FIFO; wins over push and pop
//   count       number of valid entries
//   head        registered head entry, stable until popped
module m_ifetch_fifo
  import m_ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  entry_t                 din,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output entry_t                 head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      // push and pop together (also legal when full) leave count unchanged
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/m_ifetch.sv
// Instruction fetch unit: Wishbone-classic reads at a sequential PC, words
// buffered in a small FIFO and handed to the core over valid/ready.
// A redirect flushes the buffer and restarts fetch at redirect_pc.
// Optional feature macro: M_IFETCH_BUSERR_EN adds wb_err_i; an errored
// fetch delivers a NOP flagged with instr_fault and halts fetch until the
// next redirect.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   redirect, redirect_pc    flush and restart fetch (pc bits [1:0] forced 0)
//   wb_cyc_o, wb_stb_o       bus cycle / strobe (identical, classic)
//   wb_adr_o                 word-aligned read address
//   wb_ack_i, wb_dat_i       read termination and data
//   wb_err_i                 bus error (only with M_IFETCH_BUSERR_EN)
//   instr_valid, instr_ready head-word handshake
//   instr, instr_pc          head word and its address
//   instr_fault              head word came from an errored access
module m_ifetch
  import m_ifetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [31:0] wb_adr_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i,
`ifdef M_IFETCH_BUSERR_EN
  input  logic        wb_err_i,
`endif
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_t          state_q;
  state_t          state_d;
  logic [31:0]     pc_q;
  logic [31:0]     adr_q;
  logic            halt_q;
  logic            bus_err;
  logic            push;
  logic            pop;
  entry_t          push_entry;
  entry_t          head;
  logic [CW-1:0]   count;

`ifdef M_IFETCH_BUSERR_EN
  assign bus_err = wb_err_i;
`else
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    push_entry = '{instr: wb_dat_i, pc: adr_q, fault: 1'b0};
    case (state_q)
      IDLE: begin
        // issue only with a free slot, so a later push can never overflow
        if (!redirect && !halt_q && count < CW'(DEPTH)) state_d = BUS;
      end
      BUS: begin
        if (wb_ack_i || bus_err) begin
          state_d = IDLE;
          push    = !redirect;
          if (bus_err) begin
            push_entry.instr = NOP;
            push_entry.fault = 1'b1;
          end
        end else if (redirect) begin
          // classic bus cannot abort: wait out the cycle and drop its data
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (wb_ack_i || bus_err) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      adr_q   <= RESET_PC;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == BUS) adr_q <= pc_q;
      if (redirect) begin
        pc_q   <= redirect_pc & ~32'h0000_0003;
        halt_q <= 1'b0;
      end else if (push) begin
        pc_q <= pc_q + 32'd4;
        if (bus_err) halt_q <= 1'b1;
      end
    end
  end

  assign pop = instr_valid && instr_ready && !redirect;

  m_ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .flush (redirect),
    .count (count),
    .head  (head)
  );

  assign wb_cyc_o    = (state_q != IDLE);
  assign wb_stb_o    = wb_cyc_o;
  assign wb_adr_o    = adr_q;
  assign instr_valid = (count != '0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign instr_fault = head.fault;

endmodule

// File: tb/tb_m_ifetch.sv
// Directed testbench for m_ifetch (DEPTH=2, RESET_PC=0x100).
// Bus slave returns adr ^ 32'hC0DE_0000 in the first BUS cycle unless
// hold_ack stalls it. With M_IFETCH_BUSERR_EN, a read of err_adr ends in err.
module tb_m_ifetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_adr_o;
  logic        wb_ack_i = 1'b0;
  logic [31:0] wb_dat_i = '0;
`ifdef M_IFETCH_BUSERR_EN
  logic        wb_err_i = 1'b0;
  logic [31:0] err_adr = 32'h1;
`endif
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_fault;

  m_ifetch #(
    .DEPTH    (2),
    .RESET_PC (32'h0000_0100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_adr_o    (wb_adr_o),
    .wb_ack_i    (wb_ack_i),
    .wb_dat_i    (wb_dat_i),
`ifdef M_IFETCH_BUSERR_EN
    .wb_err_i    (wb_err_i),
`endif
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_fault (instr_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } acc_t;

  acc_t        acc_log[$];
  logic [31:0] bus_log[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        hold_ack = 1'b0;
  logic        cyc_prev = 1'b0;
  logic [31:0] acked_adr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bus_at(input int i);
    return (i < bus_log.size()) ? bus_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic acc_t acc_at(input int i);
    acc_t d;
    d = '{instr: 32'hDEAD_BEEF, pc: 32'hDEAD_BEEF, fault: 1'bx};
    return (i < acc_log.size()) ? acc_log[i] : d;
  endfunction

  task automatic wait_acc(input int n, input string tag);
    for (int i = 0; i < 100 && acc_log.size() < n; i++) @(negedge clk);
    check(tag, 32'(acc_log.size() >= n), 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] a);
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = a;
    @(negedge clk);
    redirect = 1'b0;
    bus_log.delete();
    acc_log.delete();
  endtask

  // Wishbone slave: reacts just after the rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
`ifdef M_IFETCH_BUSERR_EN
      if (!rst_n || wb_ack_i || wb_err_i) begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
      end else if (wb_cyc_o && wb_stb_o && !hold_ack) begin
        if (wb_adr_o == err_adr) wb_err_i = 1'b1;
        else begin
          wb_ack_i = 1'b1;
          wb_dat_i = wb_adr_o ^ 32'hC0DE_0000;
        end
      end
`else
      if (!rst_n || wb_ack_i) begin
        wb_ack_i = 1'b0;
      end else if (wb_cyc_o && wb_stb_o && !hold_ack) begin
        wb_ack_i = 1'b1;
        wb_dat_i = wb_adr_o ^ 32'hC0DE_0000;
      end
`endif
    end
  end

  // Monitor: logs bus cycle starts and accepted words
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (wb_cyc_o && !cyc_prev) bus_log.push_back(wb_adr_o);
        if (instr_valid && instr_ready && !redirect)
          acc_log.push_back('{instr: instr, pc: instr_pc, fault: instr_fault});
      end
      cyc_prev = wb_cyc_o;
    end
  end

  initial begin
    instr_ready = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_cyc",   32'(wb_cyc_o),    32'd0);
    check("rst_stb",   32'(wb_stb_o),    32'd0);
    check("rst_adr",   wb_adr_o,         32'h0000_0100);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr,            32'd0);
    check("rst_pc",    instr_pc,         32'd0);
    check("rst_fault", 32'(instr_fault), 32'd0);
    rst_n = 1'b1;

    // 1: sequential fetch from RESET_PC, first-word latency
    for (int i = 0; i < 20 && !wb_ack_i; i++) @(negedge clk);
    check("t1_ack_seen",     32'(wb_ack_i),    32'd1);
    check("t1_valid_at_ack", 32'(instr_valid), 32'd0);
    @(negedge clk);
    check("t1_valid_next",   32'(instr_valid), 32'd1);
    check("t1_first_pc",     instr_pc,         32'h0000_0100);
    check("t1_first_instr",  instr,            32'hC0DE_0100);
    wait_acc(3, "t1_acc_timeout");
    check("t1_acc0_pc", acc_at(0).pc, 32'h0000_0100);
    check("t1_acc1_pc", acc_at(1).pc, 32'h0000_0104);
    check("t1_acc2_pc", acc_at(2).pc, 32'h0000_0108);
    check("t1_acc2_instr", acc_at(2).instr, 32'hC0DE_0108);
    check("t1_bus0", bus_at(0), 32'h0000_0100);
    check("t1_bus1", bus_at(1), 32'h0000_0104);
    check("t1_bus2", bus_at(2), 32'h0000_0108);

    // 2: backpressure fills the FIFO, fetch stalls, resumes on ready
    instr_ready = 1'b0;
    do_redirect(32'h0000_0000);
    repeat (20) @(negedge clk);
    check("t2_issued",     32'(bus_log.size()), 32'd2);
    check("t2_bus0",       bus_at(0),           32'h0000_0000);
    check("t2_bus1",       bus_at(1),           32'h0000_0004);
    check("t2_cyc_held",   32'(wb_cyc_o),       32'd0);
    check("t2_valid",      32'(instr_valid),    32'd1);
    check("t2_head_pc",    instr_pc,            32'h0000_0000);
    check("t2_head_instr", instr,               32'hC0DE_0000);
    instr_ready = 1'b1;
    wait_acc(3, "t2_acc_timeout");
    check("t2_acc0_pc", acc_at(0).pc, 32'h0000_0000);
    check("t2_acc1_pc", acc_at(1).pc, 32'h0000_0004);
    check("t2_acc2_pc", acc_at(2).pc, 32'h0000_0008);
    check("t2_bus2",    bus_at(2),    32'h0000_0008);

    // 3: redirect during a stalled BUS cycle -> DRAIN
    do_redirect(32'h0000_0010);
    hold_ack = 1'b1;
    for (int i = 0; i < 10 && !(wb_cyc_o && wb_adr_o == 32'h10); i++) @(negedge clk);
    check("t3_bus_at_10", wb_adr_o, 32'h0000_0010);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_2002;
    @(negedge clk);
    redirect = 1'b0;
    check("t3_drain_cyc", 32'(wb_cyc_o), 32'd1);
    check("t3_drain_adr", wb_adr_o,      32'h0000_0010);
    @(negedge clk);
    check("t3_drain_cyc2",  32'(wb_cyc_o),    32'd1);
    check("t3_drain_valid", 32'(instr_valid), 32'd0);
    hold_ack = 1'b0;
    wait_acc(1, "t3_acc_timeout");
    check("t3_acc0_pc",    acc_at(0).pc,    32'h0000_2000);
    check("t3_acc0_instr", acc_at(0).instr, 32'hC0DE_2000);
    check("t3_bus0",       bus_at(0),       32'h0000_0010);
    check("t3_bus1",       bus_at(1),       32'h0000_2000);

    // 4: redirect in the same cycle as ack
    for (int i = 0; i < 20 && !wb_ack_i; i++) @(negedge clk);
    check("t4_ack_seen", 32'(wb_ack_i), 32'd1);
    acked_adr   = wb_adr_o;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0400;
    @(negedge clk);
    redirect = 1'b0;
    bus_log.delete();
    acc_log.delete();
    check("t4_valid_flushed", 32'(instr_valid), 32'd0);
    check("t4_no_drain",      32'(wb_cyc_o),    32'd0);
    wait_acc(1, "t4_acc_timeout");
    check("t4_acc0_pc",    acc_at(0).pc,    32'h0000_0400);
    check("t4_acc0_instr", acc_at(0).instr, 32'hC0DE_0400);
    check("t4_bus0",       bus_at(0),       32'h0000_0400);

    // 5: PC wraps past 0xFFFF_FFFC; low redirect bits ignored
    do_redirect(32'hFFFF_FFFE);
    wait_acc(2, "t5_acc_timeout");
    check("t5_bus0",       bus_at(0),             32'hFFFF_FFFC);
    check("t5_bus1",       bus_at(1),             32'h0000_0000);
    check("t5_acc0_pc",    acc_at(0).pc,          32'hFFFF_FFFC);
    check("t5_acc0_instr", acc_at(0).instr,       32'h3F21_FFFC);
    check("t5_acc1_pc",    acc_at(1).pc,          32'h0000_0000);
    check("t5_acc1_instr", acc_at(1).instr,       32'hC0DE_0000);
    check("t5_acc0_fault", 32'(acc_at(0).fault),  32'd0);

`ifdef M_IFETCH_BUSERR_EN
    // 6: bus error -> flagged NOP, fetch halts until redirect
    err_adr = 32'h0000_0040;
    do_redirect(32'h0000_0040);
    wait_acc(1, "t6_acc_timeout");
    check("t6_instr", acc_at(0).instr,      32'h0000_0013);
    check("t6_pc",    acc_at(0).pc,         32'h0000_0040);
    check("t6_fault", 32'(acc_at(0).fault), 32'd1);
    repeat (10) @(negedge clk);
    check("t6_halt_issued", 32'(bus_log.size()), 32'd1);
    check("t6_halt_cyc",    32'(wb_cyc_o),       32'd0);
    err_adr = 32'h1;
    do_redirect(32'h0000_0080);
    wait_acc(1, "t6_resume_timeout");
    check("t6_resume_pc",    acc_at(0).pc,         32'h0000_0080);
    check("t6_resume_fault", 32'(acc_at(0).fault), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
